// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word/double load-store unit over a 64-bit word memory
// Sub-double stores read-modify-write the target word; faults complete without touching memory.
module load_store_unit #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        fault,
    output logic        mem_E,
    output logic [63:0] mem_address,
    output logic [63:0] mem_write_data,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [63:0] mem_read_data
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_EXT  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    logic [2:0]  state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] merge_q, merge_d;
    logic [63:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;

    logic        accept;
    logic        misaligned;
    logic        out_of_range;
    logic [5:0]  shamt;
    logic [63:0] shifted;
    logic [63:0] extracted;
    logic [63:0] lane_mask;
    logic [63:0] merged;

    assign req_ready      = (state_q == S_IDLE) && !rst;
    assign accept         = req_valid && req_ready;
    assign resp_valid     = (state_q == S_RESP);
    assign resp_rdata     = rdata_q;
    assign fault          = fault_q;
    assign mem_E          = (state_q == S_RD) || (state_q == S_WR);
    assign mem_read       = (state_q == S_RD);
    assign mem_write      = (state_q == S_WR);
    assign mem_address    = {3'b000, addr_q[63:3]};
    assign mem_write_data = merge_q;

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            2'b11:   misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
        out_of_range = {3'b000, req_addr[63:3]} >= 64'(MEM_WORDS);
    end

    // Field extraction and lane merge both work relative to byte lane addr[2:0].
    always_comb begin
        shamt   = {addr_q[2:0], 3'b000};
        shifted = mem_read_data >> shamt;
        case (size_q)
            2'b00: begin
                extracted = unsigned_q ? {56'b0, shifted[7:0]} : {{56{shifted[7]}}, shifted[7:0]};
                lane_mask = 64'h0000_0000_0000_00FF;
            end
            2'b01: begin
                extracted = unsigned_q ? {48'b0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
                lane_mask = 64'h0000_0000_0000_FFFF;
            end
            2'b10: begin
                extracted = unsigned_q ? {32'b0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
                lane_mask = 64'h0000_0000_FFFF_FFFF;
            end
            default: begin
                extracted = shifted;
                lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
            end
        endcase
        merged = (mem_read_data & ~(lane_mask << shamt)) | ((wdata_q << shamt) & (lane_mask << shamt));
    end

    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        merge_d    = merge_q;
        rdata_d    = rdata_q;
        fault_d    = fault_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    write_d    = req_write;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    if (misaligned || out_of_range) begin
                        fault_d = 1'b1;
                        rdata_d = 64'd0;
                        state_d = S_RESP;
                    end else if (req_write && (req_size == 2'b11)) begin
                        merge_d = req_wdata;
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: state_d = S_EXT;
            S_EXT: begin
                if (write_q) begin
                    merge_d = merged;
                    state_d = S_WR;
                end else begin
                    rdata_d = extracted;
                    fault_d = 1'b0;
                    state_d = S_RESP;
                end
            end
            S_WR: begin
                fault_d = 1'b0;
                state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            write_q    <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= 64'd0;
            wdata_q    <= 64'd0;
            merge_q    <= 64'd0;
            rdata_q    <= 64'd0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            merge_q    <= merge_d;
            rdata_q    <= rdata_d;
            fault_q    <= fault_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit
// Reference model keeps memory as a flat byte array and derives results from alignment/range rules.
module tb_load_store_unit;

    localparam int MEM_WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        fault;
    logic        mem_E;
    logic [63:0] mem_address;
    logic [63:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [63:0] mem_read_data;

    logic [63:0] mem [MEM_WORDS];
    logic [7:0]  ref_bytes [MEM_WORDS*8];
    logic [63:0] last_rdata;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .fault(fault), .mem_E(mem_E), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_write(mem_write), .mem_read(mem_read),
        .mem_read_data(mem_read_data)
    );

    always @(posedge clk) begin
        if (mem_E && mem_address < 64'(MEM_WORDS)) begin
            if (mem_read) mem_read_data <= mem[mem_address[9:0]];
            if (mem_write) mem[mem_address[9:0]] <= mem_write_data;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_word(input int idx);
        logic [63:0] w = 64'd0;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = ref_bytes[idx*8 + i];
        return w;
    endfunction

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 20) begin
            cycle();
            n++;
        end
        if (!req_ready) chk("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [63:0] a, input logic [63:0] wd);
        int          nbytes = 1 << sz;
        logic        flt_e = ((a % nbytes) != 0) || ((a >> 3) >= 64'(MEM_WORDS));
        int          lat_e;
        logic [63:0] rd_e = last_rdata;
        logic [63:0] val = 64'd0;
        logic        saw_e = 1'b0;
        logic [63:0] addr_seen = 64'd0;
        int          k = 1;
        if (flt_e)                lat_e = 1;
        else if (w && sz == 2'b11) lat_e = 2;
        else if (!w)              lat_e = 3;
        else                      lat_e = 4;
        if (flt_e) rd_e = 64'd0;
        else if (!w) begin
            for (int i = 0; i < nbytes; i++) val[8*i +: 8] = ref_bytes[int'(a) + i];
            if (!u && sz != 2'b11 && val[8*nbytes-1]) val = val | (64'hFFFF_FFFF_FFFF_FFFF << (8*nbytes));
            rd_e = val;
        end
        wait_ready();
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = wd;
        cycle();
        req_valid = 1'b0;
        req_wdata = $urandom;
        while (!resp_valid && k < 12) begin
            if (mem_E) begin saw_e = 1'b1; addr_seen = mem_address; end
            chk("ready_busy", {63'd0, req_ready}, 64'd0);
            cycle();
            k++;
        end
        chk("resp_seen", {63'd0, resp_valid}, 64'd1);
        chk("latency", 64'(k), 64'(lat_e));
        chk("fault", {63'd0, fault}, {63'd0, flt_e});
        chk("rdata", resp_rdata, rd_e);
        chk("ready_resp", {63'd0, req_ready}, 64'd0);
        if (flt_e) chk("fault_no_mem", {63'd0, saw_e}, 64'd0);
        else       chk("mem_address", addr_seen, a >> 3);
        last_rdata = rd_e;
        if (w && !flt_e) begin
            for (int i = 0; i < nbytes; i++) ref_bytes[int'(a) + i] = wd[8*i +: 8];
        end
        cycle();
        if (w && !flt_e) chk("mem_word", mem[int'(a >> 3)], ref_word(int'(a >> 3)));
    endtask

    initial begin
        int accepts;
        logic [63:0] a;
        logic [1:0]  sz;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 64'd0; req_wdata = 64'd0;
        last_rdata = 64'd0;
        @(negedge clk);
        chk("rst_ready", {63'd0, req_ready}, 64'd0);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_rdata", resp_rdata, 64'd0);
        chk("rst_fault", {63'd0, fault}, 64'd0);
        chk("rst_mem_E", {63'd0, mem_E}, 64'd0);
        cycle();
        rst = 1'b0;
        cycle();

        for (int i = 0; i < 64; i++) do_req(1'b1, 2'b11, 1'b0, 64'(i*8), {$urandom, $urandom});

        do_req(1'b1, 2'b11, 1'b0, 64'h10, 64'h1122334455667788);
        do_req(1'b0, 2'b11, 1'b0, 64'h10, 64'd0);
        chk("double_load_value", resp_rdata, 64'h1122334455667788);
        do_req(1'b1, 2'b00, 1'b0, 64'h13, 64'hAB);
        chk("byte_store_word", mem[2], 64'h11223344AB667788);
        do_req(1'b0, 2'b00, 1'b0, 64'h13, 64'd0);
        chk("byte_load_signed", resp_rdata, 64'hFFFFFFFFFFFFFFAB);
        do_req(1'b0, 2'b00, 1'b1, 64'h13, 64'd0);
        chk("byte_load_unsigned", resp_rdata, 64'h00000000000000AB);
        do_req(1'b1, 2'b10, 1'b0, 64'h18, 64'h80000000);
        do_req(1'b0, 2'b10, 1'b0, 64'h18, 64'd0);
        chk("word_load_signed", resp_rdata, 64'hFFFFFFFF80000000);
        do_req(1'b0, 2'b10, 1'b1, 64'h18, 64'd0);
        chk("word_load_unsigned", resp_rdata, 64'h0000000080000000);
        do_req(1'b0, 2'b01, 1'b0, 64'h11, 64'd0);
        do_req(1'b0, 2'b11, 1'b0, 64'h2000, 64'd0);
        do_req(1'b0, 2'b11, 1'b0, 64'h10, 64'd0);

        // Reset landing in WR of a byte store must abort the write.
        wait_ready();
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 64'h21; req_wdata = 64'h5A;
        cycle();
        req_valid = 1'b0;
        for (int n = 0; n < 10 && !mem_write; n++) cycle();
        chk("wr_reached", {63'd0, mem_write}, 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_mem_write", {63'd0, mem_write}, 64'd0);
        chk("rst_mid_mem_E", {63'd0, mem_E}, 64'd0);
        chk("rst_mid_ready", {63'd0, req_ready}, 64'd0);
        chk("rst_mid_rdata", resp_rdata, 64'd0);
        for (int n = 0; n < 3; n++) begin
            cycle();
            chk("rst_hold_resp", {63'd0, resp_valid}, 64'd0);
        end
        rst = 1'b0;
        last_rdata = 64'd0;
        for (int n = 0; n < 5; n++) begin
            cycle();
            chk("post_rst_resp", {63'd0, resp_valid}, 64'd0);
        end
        chk("rst_word_kept", mem[4], ref_word(4));

        // A load occupies IDLE, RD, EXT, RESP: one acceptance every four cycles.
        wait_ready();
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b11; req_unsigned = 1'b0;
        req_addr = 64'h10;
        accepts = 0;
        for (int i = 0; i < 10; i++) begin
            chk("hold_ready", {63'd0, req_ready}, {63'd0, (i % 4) == 0});
            if (req_ready) accepts++;
            cycle();
        end
        req_valid = 1'b0;
        chk("hold_accepts", 64'(accepts), 64'd3);
        for (int n = 0; n < 10 && !resp_valid; n++) cycle();
        chk("hold_last_resp", {63'd0, resp_valid}, 64'd1);
        chk("hold_rdata", resp_rdata, ref_word(2));
        last_rdata = ref_word(2);
        cycle();

        for (int i = 0; i < 300; i++) begin
            sz = 2'($urandom_range(0, 3));
            a = 64'($urandom_range(0, 511));
            if ($urandom_range(0, 1) == 1) a = a & ~64'((1 << sz) - 1);
            if ($urandom_range(0, 15) == 0) a = 64'h2000 + 64'($urandom_range(0, 4095));
            if ($urandom_range(0, 31) == 0) a = {$urandom, $urandom} & ~64'h7;
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, {$urandom, $urandom});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, the number of 64-bit words in the attached data memory.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, 1 bit: a request is present.
REQ-005 SHALL have port req_ready, output, 1 bit: the unit accepts a request at this edge.
REQ-006 SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port req_size, input, 2 bits: 00 byte, 01 half, 10 word, 11 double.
REQ-008 SHALL have port req_unsigned, input, 1 bit: zero-extend loads; ignored for double and for stores.
REQ-009 SHALL have port req_addr, input, 64 bits: byte address.
REQ-010 SHALL have port req_wdata, input, 64 bits: store data, right-aligned.
REQ-011 SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata, output, 64 bits: load result, held until the next response.
REQ-013 SHALL have port fault, output, 1 bit: misaligned or out-of-range access; valid with resp_valid.
REQ-014 SHALL have port mem_E, output, 1 bit: data-memory enable.
REQ-015 SHALL have port mem_address, output, 64 bits: word index, equal to {3'b0, addr[63:3]}.
REQ-016 SHALL have port mem_write_data, output, 64 bits: data-memory write data.
REQ-017 SHALL have port mem_write, output, 1 bit: data-memory write strobe.
REQ-018 SHALL have port mem_read, output, 1 bit: data-memory read strobe.
REQ-019 SHALL have port mem_read_data, input, 64 bits: registered memory output, valid on the cycle after a read edge.

Function
REQ-020 SHALL implement states IDLE, RD, EXT, WR and RESP; req_ready = 1 only in IDLE with rst low.
REQ-021 SHALL accept a request on an edge where req_valid and req_ready are both 1, capturing all req_* fields; req_valid SHALL be ignored in any other state.
REQ-022 SHALL apply these alignment rules, using o = addr[2:0]: half requires addr[0]=0, word requires addr[1:0]=0, double requires o=0.
REQ-023 SHALL treat an access as out of range when addr[63:3] >= MEM_WORDS.
REQ-024 SHALL route a faulting request IDLE->RESP with fault=1 and resp_rdata=0, with no memory access.
REQ-025 SHALL route a load, or a byte/half/word store, IDLE->RD->EXT; a load then goes EXT->RESP, and a sub-double store goes EXT->WR->RESP.
REQ-026 SHALL route a double store IDLE->WR->RESP.
REQ-027 SHALL meet these latencies, counting the acceptance edge as edge 1, with resp_valid high in the cycle after: fault edge 1; double store edge 2; load edge 3; sub-double store edge 4.
REQ-028 SHALL decode memory controls from state: mem_E=1 only in RD and WR, mem_read=1 only in RD, mem_write=1 only in WR, and all three 0 elsewhere.
REQ-029 SHALL use little-endian lanes: byte lane k occupies bits [8k+7:8k], and the accessed field starts at lane o.
REQ-030 SHALL, in EXT for a load, register into resp_rdata the field extracted from mem_read_data, sign-extended to 64 bits unless req_unsigned=1.
REQ-031 SHALL, in EXT for a store, register a merge word equal to mem_read_data with lanes o..o+size-1 replaced by the low bytes of req_wdata, all other lanes unchanged.
REQ-032 SHALL drive mem_write_data from the merge register; for a double store, the merge register SHALL equal req_wdata.
REQ-033 SHALL hold resp_valid=1 for exactly one cycle in RESP, which always returns to IDLE.
REQ-034 SHALL hold resp_rdata for stores at its previous value, and SHALL clear fault on the next non-faulting response.

Reset
REQ-035 SHALL, while rst is high, force state to IDLE and clear resp_rdata, fault, the merge register and the captured address/fields to 0, independent of clk.
REQ-036 SHALL, on reset mid-operation, deassert mem_E, mem_write and mem_read in the same cycle and drop the pending request with no resp_valid.
REQ-037 SHALL hold req_ready=0 while rst is high.

Verification
REQ-038 SHALL cover: double store to 0x10 of 0x1122334455667788, then double load of 0x10 -> mem_address=2 and resp_rdata=0x1122334455667788 at edge 3.
REQ-039 SHALL cover: byte store 0xAB to 0x13 -> word becomes 0x11223344AB667788; signed byte load of 0x13 -> 0xFFFFFFFFFFFFFFAB; unsigned -> 0x00000000000000AB.
REQ-040 SHALL cover: word store 0x80000000 to 0x18, then signed word load -> 0xFFFFFFFF80000000, and unsigned word load -> 0x0000000080000000.
REQ-041 SHALL cover: half load at 0x11, and load at 0x2000 with MEM_WORDS=1024 -> fault=1 and resp_rdata=0 at edge 1, with mem_E never asserted.
REQ-042 SHALL cover: rst pulsed while in WR of a byte store -> mem_write drops immediately, no resp_valid, and the target word is unchanged.
REQ-043 SHALL cover: req_valid held high for 10 cycles -> exactly one request accepted per IDLE visit, and req_ready=0 in RD, EXT, WR and RESP.
